// File: rtl/data_mem_if.sv
// Request/response bus between the execute stage and the data memory.
// valid/ready: a request transfers on a rising edge where req_valid && req_ready; resp_valid is a one-cycle pulse.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        misaligned;

    modport master (
        output req_valid, we, size, unsigned_ld, addr, write_data,
        input  req_ready, resp_valid, read_data, misaligned
    );

    modport slave (
        input  req_valid, we, size, unsigned_ld, addr, write_data,
        output req_ready, resp_valid, read_data, misaligned
    );
endinterface

// File: rtl/data_mem.sv
// Single-port data memory with fixed response latency, byte/half/word access,
// little-endian lane steering, load extension and misalignment detection.
module data_mem #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    data_mem_if.slave   bus,
    output logic [1:0]  state_dbg
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               req_ready;
    logic               resp_valid;
    logic               accept;

    logic               we_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [IDX_W+1:0]   addr_q;
    logic [31:0]        wdata_q;

    logic [31:0]        mem [DEPTH];
    logic [IDX_W-1:0]   idx;
    logic [1:0]         lane;
    logic               mis;
    logic [31:0]        word;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_data;
    logic [3:0]         be;
    logic [31:0]        wlanes;
    logic               do_write;
    logic               unused_addr_hi;

    assign state_dbg = state;
    assign accept    = bus.req_valid && req_ready;

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) state_nxt = (LATENCY == 1) ? RESP : BUSY;
            end
            BUSY: begin
                if (cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) cnt <= CNT_LOAD;
            else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    // Request fields are held for the whole transaction so the bus may change freely after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.we;
            size_q  <= bus.size;
            uns_q   <= bus.unsigned_ld;
            addr_q  <= bus.addr[IDX_W+1:0];
            wdata_q <= bus.write_data;
        end
    end

    // Upper address bits are deliberately ignored: the array aliases modulo DEPTH*4 bytes.
    assign unused_addr_hi = ^bus.addr[31:IDX_W+2];

    assign idx  = addr_q[IDX_W+1:2];
    assign lane = addr_q[1:0];

    always_comb begin
        mis = 1'b0;
        case (size_q)
            2'b00: mis = 1'b0;
            2'b01: mis = lane[0];
            2'b10: mis = (lane != 2'b00);
            default: mis = 1'b1;
        endcase
    end

    assign word    = mem[idx];
    assign ld_byte = word[{lane, 3'b000} +: 8];
    assign ld_half = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = word;
        case (size_q)
            2'b00: ld_data = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01: ld_data = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = word;
        endcase
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.read_data  = (resp_valid && !we_q && !mis) ? ld_data : 32'h0;
    assign bus.misaligned = resp_valid ? mis : 1'b0;

    // Store data is replicated across lanes so the byte enables alone pick what lands where.
    always_comb begin
        be     = 4'b0000;
        wlanes = wdata_q;
        case (size_q)
            2'b00: begin
                be     = 4'b0001 << lane;
                wlanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                be     = 4'b1111;
                wlanes = wdata_q;
            end
            default: begin
                be     = 4'b0000;
                wlanes = wdata_q;
            end
        endcase
    end

    // A reset on the RESP edge wins, so a dropped store never reaches the array.
    assign do_write = resp_valid && we_q && !mis && !rst;

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed table, multi-cycle corner sequences,
// and randomized traffic against a byte-level reference model.
module tb_data_mem;
    localparam int DEPTH     = 1024;
    localparam int LATENCY   = 2;
    localparam int MEM_BYTES = DEPTH * 4;
    localparam int TIMEOUT   = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;

    data_mem_if bus ();

    data_mem #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  model_mem [int];

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (sz == 2'd3);
    endfunction

    function automatic int byte_key(input logic [31:0] a, input int b);
        logic [31:0] ba;
        ba = (a + 32'(b)) % 32'(MEM_BYTES);
        return int'(ba);
    endfunction

    // Applies one access to the model and returns the read_data the memory must produce.
    function automatic logic [31:0] model_access(input logic we, input logic [1:0] sz, input logic uns,
                                                 input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] val;
        int n;
        val = 32'h0;
        if (model_mis(sz, a)) return 32'h0;
        n = 1 << sz;
        if (we) begin
            for (int b = 0; b < n; b++) model_mem[byte_key(a, b)] = wd[8*b +: 8];
            return 32'h0;
        end
        for (int b = 0; b < n; b++) val[8*b +: 8] = model_mem[byte_key(a, b)];
        if (sz == 2'd0 && !uns && val[7])  val = val | 32'hFFFF_FF00;
        if (sz == 2'd1 && !uns && val[15]) val = val | 32'hFFFF_0000;
        return val;
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic mis, output int lat);
        int waits;
        @(negedge clk);
        bus.we          = we;
        bus.size        = sz;
        bus.unsigned_ld = uns;
        bus.addr        = a;
        bus.write_data  = wd;
        bus.req_valid   = 1'b1;
        waits = 0;
        while (!bus.req_ready && waits < TIMEOUT) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.req_ready) chk("req_ready_timeout", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.addr       = 32'hA5A5_A5A5;
        bus.write_data = 32'h5A5A_5A5A;
        lat = 1;
        while (!bus.resp_valid && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.resp_valid) chk("resp_timeout", 32'(bus.resp_valid), 32'h1);
        rd  = bus.read_data;
        mis = bus.misaligned;
    endtask

    initial begin
        logic [31:0] rd, a, wd, exp;
        logic        mis, we, uns, exp_mis;
        logic [1:0]  sz;
        int          lat, accepts, pulses, first_pulse, second_pulse, second_accept;

        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.we          = 1'b0;
        bus.size        = 2'b00;
        bus.unsigned_ld = 1'b0;
        bus.addr        = 32'h0;
        bus.write_data  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready",  32'(bus.req_ready),  32'h1);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("reset_read_data",  bus.read_data,       32'h0);
        chk("reset_misaligned", 32'(bus.misaligned), 32'h0);
        rst = 1'b0;

        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEAD_BEEF, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h13,   32'h0,         32'hFFFF_FFDE, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h13,   32'h0,         32'h0000_00DE, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h10,   32'h0,         32'hFFFF_FFEF, 1'b0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h12,   32'hAAAA_1234, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,         32'h1234_BEEF, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h11,   32'hFFFF_FF55, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,         32'h1234_55EF, 1'b0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h11,   32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,         32'h1234_55EF, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h13,   32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h12,   32'h0,         32'h0000_1234, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h10,   32'h0,         32'h0000_55EF, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h11,   32'h0,         32'h0000_0055, 1'b0});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1010, 32'h0,         32'h1234_55EF, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            void'(model_access(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd));
            do_req(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd, rd, mis, lat);
            chk($sformatf("vec%0d_read_data", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_misaligned", i), 32'(mis), 32'(vecs[i].exp_mis));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LATENCY));
        end

        // Two loads with req_valid held high: one accept per LATENCY+1 cycles.
        accepts = 0; pulses = 0; first_pulse = -1; second_pulse = -1; second_accept = -1;
        @(negedge clk);
        bus.we = 1'b0; bus.size = 2'd2; bus.unsigned_ld = 1'b0; bus.addr = 32'h10;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (accepts >= 2) bus.req_valid = 1'b0;
            if (bus.resp_valid) begin
                pulses++;
                if (pulses == 1) first_pulse = i;
                if (pulses == 2) second_pulse = i;
                chk("b2b_read_data", bus.read_data, 32'h1234_55EF);
                chk("b2b_ready_in_resp", 32'(bus.req_ready), 32'h0);
            end
            if (bus.req_valid && bus.req_ready) begin
                accepts++;
                if (accepts == 2) second_accept = i;
            end
        end
        chk("b2b_accepts", 32'(accepts), 32'h2);
        chk("b2b_pulses", 32'(pulses), 32'h2);
        chk("b2b_pulse_gap", 32'(second_pulse - first_pulse), 32'(LATENCY + 1));
        chk("b2b_second_accept", 32'(second_accept - first_pulse), 32'h1);

        // Store accepted, then reset on the following cycle: the store must vanish.
        @(negedge clk);
        bus.we = 1'b1; bus.size = 2'd2; bus.addr = 32'h10; bus.write_data = 32'hFFFF_FFFF;
        bus.req_valid = 1'b1;
        chk("rst_mid_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 2 * LATENCY + 4; i++) begin
            @(negedge clk);
            rst = 1'b0;
            if (bus.resp_valid) pulses++;
        end
        chk("rst_mid_no_resp", 32'(pulses), 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, mis, lat);
        chk("rst_mid_contents", rd, 32'h1234_55EF);
        do_req(1'b0, 2'd2, 1'b0, 32'h1010, 32'h0, rd, mis, lat);
        chk("wrap_after_reset", rd, 32'h1234_55EF);

        // Randomized traffic in a region seeded with known words.
        for (int k = 0; k < 16; k++) begin
            wd = $urandom;
            void'(model_access(1'b1, 2'd2, 1'b0, 32'h200 + 32'(4 * k), wd));
            do_req(1'b1, 2'd2, 1'b0, 32'h200 + 32'(4 * k), wd, rd, mis, lat);
        end
        for (int n = 0; n < 200; n++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            a   = 32'h200 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom);
            wd  = $urandom;
            exp_mis = model_mis(sz, a);
            exp_q.push_back(model_access(we, sz, uns, a, wd));
            do_req(we, sz, uns, a, wd, rd, mis, lat);
            exp = exp_q.pop_front();
            chk($sformatf("rand%0d_read_data we=%0d sz=%0d a=%h", n, we, sz, a), rd, exp);
            chk($sformatf("rand%0d_misaligned", n), 32'(mis), 32'(exp_mis));
            chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(LATENCY));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
Single-port data memory responder for the single-cycle/multi-cycle core. It serves the load/store requests the execute stage issues on its addr/write_data outputs, and returns read_data for the register-file writeback mux. It uses a valid/ready request handshake, a fixed programmable response latency, byte/half/word access sizes, little-endian lane steering, load sign/zero extension and misalignment detection.

Parameters:
DEPTH, 1024, number of 32-bit words in the array (power of 2, >=2)
LATENCY, 2, cycles from request acceptance to response (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
we  input  1  1=store, 0=load
size  input  2  00=byte, 01=half, 10=word, 11=illegal
unsigned_ld  input  1  1=zero-extend load, 0=sign-extend (ignored for word/store)
addr  input  32  byte address (from ALU result)
write_data  input  32  store data, least-significant bits used for byte/half
resp_valid  output  1  one-cycle response pulse
read_data  output  32  load result, valid only with resp_valid
misaligned  output  1  error flag, valid only with resp_valid

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset: state=IDLE, req_ready=1 (combinational from IDLE), resp_valid=0, read_data=0, misaligned=0, latency counter=0. The memory array is not cleared.
- Reset mid-operation: the pending request is dropped. No response is produced and a pending store is never written.
- Accept: req_valid && req_ready at a clock edge. On accept, latch we, size, unsigned_ld, addr and write_data. Request inputs are ignored at all other times.
- FSM:
  - IDLE: req_ready=1. On accept, go to RESP if LATENCY==1, else go to BUSY with counter=LATENCY-2.
  - BUSY: req_ready=0. Decrement counter each cycle; go to RESP when counter==0.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle, then go to IDLE.
- Latency: a request accepted at edge T produces resp_valid high in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance. The next accept occurs no earlier than the cycle after RESP, so back-to-back throughput is one request per LATENCY+1 cycles.
- Index: word index = addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4. Lane = addr[1:0], little-endian (lane 0 = bits 7:0).
- Misaligned when any of the following holds:
  - size=01 and addr[0]=1
  - size=10 and addr[1:0]!=0
  - size=11
- For a misaligned request: misaligned=1, read_data=0, no memory write.
- Store: performed at the RESP cycle edge.
  - Byte writes write_data[7:0] into the lane.
  - Half writes write_data[15:0] into lanes {addr[1],0}+1 : {addr[1],0}.
  - Word writes all 32 bits. Untouched lanes keep their value.
  - read_data=0 on store responses.
- Load: the array is read during RESP. The selected byte or half is extended to 32 bits: sign-extended unless unsigned_ld=1. Word loads return the whole word.
- Outside RESP, read_data and misaligned are driven 0.
- Memory contents persist across reset.

Test Plan:
- Store word 0xDEADBEEF to addr 0x10 with LATENCY=2 -> resp_valid pulses 2 cycles after accept with read_data=0. A word load from 0x10 then returns 0xDEADBEEF with misaligned=0.
- Byte load from 0x13: with unsigned_ld=0 -> 0xFFFFFFDE; with unsigned_ld=1 -> 0x000000DE. A byte load from 0x10 with signed extension -> 0xFFFFFFEF.
- Store half 0x1234 to 0x12, then word load from 0x10 -> 0x1234BEEF. Store byte 0x55 to 0x11, then word load -> 0x123455EF.
- Word store to 0x11 with data 0 -> misaligned=1, read_data=0. A following word load from 0x10 still returns 0x123455EF. Half load from 0x13 -> misaligned=1.
- req_valid held high for two loads -> req_ready=0 during BUSY and RESP. The second request is accepted the cycle after resp_valid, and exactly two resp_valid pulses occur, 3 cycles apart.
- Store 0xFFFFFFFF to 0x10 accepted, then rst=1 on the next cycle -> no resp_valid. After reset, a word load from 0x10 returns the prior value 0x123455EF. Also verify address wrap: with DEPTH=1024, a load from 0x1010 returns the same data as 0x10.
